// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch unit.
// Opcodes, fetch FSM states and the default PC width.
package fetch_pkg;

  localparam int PC_W_DEF = 9;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_MUL = 6'd2;
  localparam logic [5:0] OP_AND = 6'd3;
  localparam logic [5:0] OP_OR  = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_NOT = 6'd6;
  localparam logic [5:0] OP_NOR = 6'd7;
  localparam logic [5:0] OP_SLA = 6'd8;
  localparam logic [5:0] OP_SRA = 6'd9;
  localparam logic [5:0] OP_SLL = 6'd10;
  localparam logic [5:0] OP_SRL = 6'd11;
  localparam logic [5:0] OP_BEQ = 6'd14;
  localparam logic [5:0] OP_J   = 6'd20;
  localparam logic [5:0] OP_JR  = 6'd21;
  localparam logic [5:0] OP_JAL = 6'd22;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } state_e;

  function automatic logic is_jump(
    input logic [31:0] ins
  );
    return ins[31:26] == OP_J;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO holding {pc, instruction} entries.
// Ports: clk_i/rst_i, push_i+wdata_i, pop_i, flush_i, rdata_o/valid_o/count_o.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign valid_o = cnt_q != '0;
  // Empty FIFO shows zeros so the head reads 0 out of reset.
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generator, imem requester and prefetch FIFO front end.
// Ports: clk/reset/run, imem_en/addr/rdata, instr_valid/ready/instruction/
// instr_pc, redirect_valid/pc, fifo_count. Option: FETCH_JUMP_PREDECODE_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  output logic                        imem_en,
  output logic [PC_W-1:0]             imem_addr,
  input  logic [31:0]                 imem_rdata,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [31:0]                 instruction,
  output logic [PC_W-1:0]             instr_pc,
  input  logic                        redirect_valid,
  input  logic [PC_W-1:0]             redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ipc_q;
  logic            infl_q, infl_d;
  logic            push, pop, jump;
  logic [PC_W-1:0] jump_pc;
  logic [CW:0]     need;
  logic            room;
  logic [PC_W+31:0] head;

  // A redirect discards the response arriving this cycle.
  assign push = infl_q && !redirect_valid;
  assign pop  = instr_valid && instr_ready;

`ifdef FETCH_JUMP_PREDECODE_EN
  assign jump    = push && is_jump(imem_rdata);
  assign jump_pc = imem_rdata[PC_W-1:0];
`else
  assign jump    = 1'b0;
  assign jump_pc = '0;
`endif

  always_comb begin
    imem_en = 1'b0;
    unique case (state_q)
      IDLE:  imem_en = 1'b0;
      FETCH: imem_en = run;
      FULL:  imem_en = 1'b0;
      default: imem_en = 1'b0;
    endcase

    infl_d = imem_en && !redirect_valid && !jump;

    // Occupancy after this edge plus the next cycle's request
    // must fit, so every response has a slot when it returns.
    need = {1'b0, fifo_count}
         + (CW+1)'(push)
         + (CW+1)'(infl_d)
         + (CW+1)'(1)
         - (CW+1)'(pop);
    room = need <= (CW+1)'(FIFO_DEPTH);

    pc_d = pc_q;
    if (redirect_valid)   pc_d = redirect_pc;
    else if (jump)        pc_d = jump_pc;
    else if (imem_en)     pc_d = pc_q + 1'b1;

    state_d = state_q;
    if (redirect_valid)   state_d = run ? FETCH : IDLE;
    else if (!run)        state_d = IDLE;
    else                  state_d = room ? FETCH : FULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      infl_q  <= 1'b0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      if (imem_en) ipc_q <= pc_q;
    end
  end

  assign imem_addr = pc_q;

  fetch_fifo #(
    .W     (PC_W + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({ipc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head),
    .valid_o (instr_valid),
    .count_o (fifo_count)
  );

  assign {instr_pc, instruction} = head;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream neighbour of the single-cycle execute/register-file stage.
- Generates the program counter and reads 32-bit instructions from a synchronous instruction memory (1-cycle read latency).
- Buffers fetched instructions in a small prefetch FIFO and presents them to execute with a valid/ready handshake.
- Accepts PC redirects (branch/jump resolution) from downstream.

Parameters:
- PC_W, 9: program counter width; word-addressed, PC counts instructions, not bytes.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable; when 0, no new memory requests are issued.
- imem_en  out  1  instruction memory read request this cycle.
- imem_addr  out  PC_W  word address of the request.
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- instr_valid  out  1  instruction/instr_pc hold a valid entry.
- instr_ready  in  1  execute accepts the entry this cycle.
- instruction  out  32  head-of-FIFO instruction.
- instr_pc  out  PC_W  address of the head instruction.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new fetch address.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, any cycle):
  - pc=RESET_PC, FIFO empty, in-flight flag cleared.
  - imem_en=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, fifo_count=0.
- State machine, states IDLE, FETCH, FULL:
  - IDLE: entered on reset. Go to FETCH when run=1.
  - FETCH: imem_en=1, imem_addr=pc, pc<=pc+1 each cycle.
  - FETCH -> FULL when fifo_count + inflight + 1 > FIFO_DEPTH, counting any pop this cycle.
  - FULL: imem_en=0. Return to FETCH when space is available.
  - FETCH or FULL -> IDLE when run=0. An outstanding in-flight response is still captured.
- In-flight tracking:
  - One-bit inflight flag plus inflight_pc register.
  - Response pushed at the edge following the request cycle.
  - Request issued only if the push is guaranteed space, so responses are never dropped.
- Latency: with an empty FIFO, an instruction requested in cycle k is presented (instr_valid=1) in cycle k+2. There is no combinational bypass from imem_rdata.
- Handshake:
  - Pop when instr_valid and instr_ready.
  - Push and pop in the same cycle are both honoured; fifo_count is unchanged.
  - The output is stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority; beats push, pop and run=0):
  - On the edge with redirect_valid=1: FIFO emptied, inflight cleared (the returning response is discarded), pc<=redirect_pc.
  - State goes to FETCH if run=1, otherwise IDLE.
  - instr_valid=0 in the next cycle.
  - First post-redirect instruction is presented 3 cycles after the redirect cycle.
- Arithmetic: pc+1 wraps modulo 2^PC_W (511 -> 0 for the default), with no error flag.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- Defined:
  - A pushed instruction with opcode [31:26]==20 (j) triggers an internal redirect to instruction[PC_W-1:0] on the push edge.
  - Later sequential requests already issued are discarded, using the same mechanism as an external redirect but without flushing the FIFO.
  - The j itself is still enqueued.
  - An external redirect_valid in the same cycle wins over the internal one.
- Undefined: all opcodes are fetched sequentially; jumps are resolved only by redirect_valid.

Decomposition:
- fetch_pkg holds:
  - opcode constants: OP_ADD=0 .. OP_SRL=11, OP_BEQ=14, OP_J=20, OP_JR=21, OP_JAL=22;
  - the state enum (IDLE, FETCH, FULL);
  - default PC_W.
- Sub-module fetch_fifo:
  - parameterised by width and depth;
  - stores {pc, instruction};
  - provides push/pop/flush/count.

Test Plan:
- Memory word n = n, run=1 after reset: instructions 0,1,2,3 presented in order, with instr_pc matching; first instr_valid exactly 2 cycles after the first imem_en.
- instr_ready=0 for 10 cycles: fifo_count reaches 4, then imem_en=0. On release, entries 0..N follow with no loss or duplication.
- FIFO full with one request in flight, redirect_pc=0x40: next accepted instr_pc=0x40 and none of the flushed addresses appear; instr_valid=0 the cycle after the redirect.
- redirect_pc=511: sequence 511, 0, 1 (wrap-around).
- Async reset asserted mid-stream between clock edges: all outputs go to reset values immediately. After release with run=1, fetch restarts at 0.
- With FETCH_JUMP_PREDECODE_EN, j (opcode 20, target 0x30) at address 5: sequence 5, 0x30, 0x31. Without the macro: 5, 6, 7.
